// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing controller: opcode encodings, flag bit
// positions, controller state encoding and small opcode-decode helpers.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int SEL_W  = 7;

  localparam logic [SEL_W-1:0] OP_ADD = 7'b1000000;
  localparam logic [SEL_W-1:0] OP_SUB = 7'b0100000;
  localparam logic [SEL_W-1:0] OP_CMP = 7'b0010000;
  localparam logic [SEL_W-1:0] OP_AND = 7'b0001000;
  localparam logic [SEL_W-1:0] OP_ORR = 7'b0000100;
  localparam logic [SEL_W-1:0] OP_EOR = 7'b0000010;
  localparam logic [SEL_W-1:0] OP_MOV = 7'b0000001;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Every one-hot pattern of the opcode bus is one of the seven legal codes.
  function automatic logic sel_legal(input logic [SEL_W-1:0] sel);
    return $onehot(sel);
  endfunction

  function automatic logic sel_is_logic(input logic [SEL_W-1:0] sel);
    return |(sel & (OP_AND | OP_ORR | OP_EOR | OP_MOV));
  endfunction

endpackage

// File: rtl/alu_rr_arb2.sv
// Two-way round-robin arbiter. prio_q names the requester favoured on a tie;
// after each executed op it moves to the requester that was not served.
module alu_rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req_i,
  input  logic       en_i,
  input  logic       upd_i,
  input  logic       upd_id_i,
  output logic [1:0] gnt_o,
  output logic       gnt_id_o
);

  logic prio_q;
  logic prio_d;

  always_comb begin
    gnt_id_o = 1'b0;
    gnt_o    = 2'b00;
    if (req_i == 2'b11) begin
      gnt_id_o = prio_q;
    end else begin
      gnt_id_o = req_i[1];
    end
    if (en_i && (|req_i)) begin
      gnt_o = gnt_id_o ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    prio_d = prio_q;
    if (upd_i) begin
      prio_d = ~upd_id_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one external combinational ALU between two requesters: arbitrates,
// registers the operation, captures the result and owns the NZCV flag register.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [SEL_W-1:0] req0_sel,
  input  logic [W-1:0]     req0_a,
  input  logic [W-1:0]     req0_b,
  input  logic             req0_setf,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [SEL_W-1:0] req1_sel,
  input  logic [W-1:0]     req1_a,
  input  logic [W-1:0]     req1_b,
  input  logic             req1_setf,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [W-1:0]     alu_data,
  input  logic [3:0]       alu_flags,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [W-1:0]     rsp_data,
  output logic [3:0]       rsp_flags,
  output logic             rsp_err,
  output logic [3:0]       flags_q
);

  state_e           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             setf_q, setf_d;
  logic             legal_q, legal_d;
  logic             id_q, id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [W-1:0]     rsp_data_q, rsp_data_d;
  logic [3:0]       rsp_flags_q, rsp_flags_d;
  logic             rsp_err_q, rsp_err_d;
  logic [3:0]       arch_flags_q, arch_flags_d;

  logic [1:0]       gnt;
  logic             gnt_id;
  logic             arb_upd;
  logic [SEL_W-1:0] acc_sel;
  logic [W-1:0]     acc_a;
  logic [W-1:0]     acc_b;
  logic             acc_setf;
  logic [3:0]       exec_flags;
  logic             exec_is_cmp;

  alu_rr_arb2 u_arb (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_i    ({req1_valid, req0_valid}),
    .en_i     (state_q == ST_IDLE),
    .upd_i    (arb_upd),
    .upd_id_i (id_q),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  assign acc_sel  = gnt_id ? req1_sel  : req0_sel;
  assign acc_a    = gnt_id ? req1_a    : req0_a;
  assign acc_b    = gnt_id ? req1_b    : req0_b;
  assign acc_setf = gnt_id ? req1_setf : req0_setf;

  // sel_q only ever holds a legal opcode or zero, so it doubles as the ALU select.
  assign exec_is_cmp = (sel_q == OP_CMP);

  always_comb begin
    exec_flags = alu_flags;
    if (sel_is_logic(sel_q)) begin
      exec_flags[FLAG_C] = 1'b0;
      exec_flags[FLAG_V] = 1'b0;
    end
  end

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    sel_d        = sel_q;
    setf_d       = setf_q;
    legal_d      = legal_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_err_d    = rsp_err_q;
    arch_flags_d = arch_flags_q;
    arb_upd      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          a_d     = acc_a;
          b_d     = acc_b;
          setf_d  = acc_setf;
          id_d    = gnt_id;
          legal_d = sel_legal(acc_sel);
          sel_d   = sel_legal(acc_sel) ? acc_sel : '0;
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_err_d   = ~legal_q;
        if (legal_q) begin
          rsp_data_d  = exec_is_cmp ? '0 : alu_data;
          rsp_flags_d = exec_flags;
          if (setf_q || exec_is_cmp) begin
            arch_flags_d = exec_flags;
          end
        end else begin
          rsp_data_d  = '0;
          rsp_flags_d = '0;
        end
        arb_upd = 1'b1;
        state_d = ST_RESP;
      end

      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          sel_d       = '0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      sel_q        <= '0;
      setf_q       <= 1'b0;
      legal_q      <= 1'b0;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
      rsp_flags_q  <= '0;
      rsp_err_q    <= 1'b0;
      arch_flags_q <= '0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      sel_q        <= sel_d;
      setf_q       <= setf_d;
      legal_q      <= legal_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_err_q    <= rsp_err_d;
      arch_flags_q <= arch_flags_d;
    end
  end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_sel   = sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_flags = rsp_flags_q;
  assign rsp_err   = rsp_err_q;
  assign flags_q   = arch_flags_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: plays the external ALU, drives both requesters and
// checks every response against an arithmetic reference model.
module tb_alu_share_ctrl;
  import alu_pkg::*;

  localparam int W = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic             p_valid [2];
  logic [SEL_W-1:0] p_sel   [2];
  logic [W-1:0]     p_a     [2];
  logic [W-1:0]     p_b     [2];
  logic             p_setf  [2];

  logic             req0_ready, req1_ready;
  logic [W-1:0]     alu_a, alu_b, alu_data, rsp_data;
  logic [SEL_W-1:0] alu_sel;
  logic [3:0]       alu_flags, rsp_flags, flags_q;
  logic             rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [32:0]      alu_sum;

  int checks = 0;
  int failures = 0;
  int op_no = 0;
  logic [3:0] flags_m;
  logic       prio_m;

  alu_share_ctrl #(.W(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req0_valid (p_valid[0]),
    .req0_ready (req0_ready),
    .req0_sel   (p_sel[0]),
    .req0_a     (p_a[0]),
    .req0_b     (p_b[0]),
    .req0_setf  (p_setf[0]),
    .req1_valid (p_valid[1]),
    .req1_ready (req1_ready),
    .req1_sel   (p_sel[1]),
    .req1_a     (p_a[1]),
    .req1_b     (p_b[1]),
    .req1_setf  (p_setf[1]),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_data   (alu_data),
    .alu_flags  (alu_flags),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_flags  (rsp_flags),
    .rsp_err    (rsp_err),
    .flags_q    (flags_q)
  );

  // External ALU stand-in; logic ops return junk C/V and idle returns junk so
  // the controller's masking and zeroing are observable.
  always_comb begin
    alu_sum   = '0;
    alu_data  = '0;
    alu_flags = '0;
    case (alu_sel)
      OP_ADD: begin
        alu_sum   = {1'b0, alu_a} + {1'b0, alu_b};
        alu_data  = alu_sum[31:0];
        alu_flags = {alu_sum[31:0] == 32'd0, alu_sum[31], alu_sum[32],
                     (alu_a[31] == alu_b[31]) && (alu_sum[31] != alu_a[31])};
      end
      OP_SUB, OP_CMP: begin
        alu_sum   = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        alu_data  = alu_sum[31:0];
        alu_flags = {alu_sum[31:0] == 32'd0, alu_sum[31], alu_sum[32],
                     (alu_a[31] != alu_b[31]) && (alu_sum[31] != alu_a[31])};
      end
      OP_AND: begin alu_data = alu_a & alu_b; alu_flags = {alu_data == 32'd0, alu_data[31], alu_b[0], alu_a[0]}; end
      OP_ORR: begin alu_data = alu_a | alu_b; alu_flags = {alu_data == 32'd0, alu_data[31], alu_b[0], alu_a[0]}; end
      OP_EOR: begin alu_data = alu_a ^ alu_b; alu_flags = {alu_data == 32'd0, alu_data[31], alu_b[0], alu_a[0]}; end
      OP_MOV: begin alu_data = alu_b;         alu_flags = {alu_data == 32'd0, alu_data[31], alu_b[0], alu_a[0]}; end
      default: begin alu_data = alu_a ^ alu_b ^ 32'hDEAD_BEEF; alu_flags = 4'hF; end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s op=%0d observed=%0h expected=%0h", tag, op_no, obs, exp);
    end
  endtask

  // Reference model from the architectural rules, using signed 64-bit arithmetic.
  function automatic void ref_op(input logic [6:0] sel, input logic [31:0] a, input logic [31:0] b,
                                 input logic setf, output logic [31:0] data, output logic [3:0] fl,
                                 output logic err, output logic upd);
    longint sa, sb, s;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s = 0; r = '0; data = '0; fl = '0; err = 1'b0;
    case (sel)
      OP_ADD: begin
        r = a + b; s = sa + sb; data = r;
        fl = {r == 32'd0, r[31], r < a, (s > SMAX) || (s < SMIN)};
      end
      OP_SUB, OP_CMP: begin
        r = a - b; s = sa - sb;
        data = (sel == OP_CMP) ? 32'd0 : r;
        fl = {r == 32'd0, r[31], a >= b, (s > SMAX) || (s < SMIN)};
      end
      OP_AND: begin r = a & b; data = r; fl = {r == 32'd0, r[31], 2'b00}; end
      OP_ORR: begin r = a | b; data = r; fl = {r == 32'd0, r[31], 2'b00}; end
      OP_EOR: begin r = a ^ b; data = r; fl = {r == 32'd0, r[31], 2'b00}; end
      OP_MOV: begin r = b;     data = r; fl = {r == 32'd0, r[31], 2'b00}; end
      default: err = 1'b1;
    endcase
    upd = !err && (setf || (sel == OP_CMP));
  endfunction

  task automatic set_req(input int p, input logic [6:0] sel, input logic [31:0] a,
                         input logic [31:0] b, input logic setf);
    p_valid[p] = 1'b1; p_sel[p] = sel; p_a[p] = a; p_b[p] = b; p_setf[p] = setf;
  endtask

  function automatic logic [6:0] rand_sel();
    logic [6:0] one;
    int r, x, y;
    one = 7'd1;
    r = int'($urandom_range(0, 9));
    if (r < 7) return one << r;
    if (r == 7) return 7'd0;
    x = int'($urandom_range(0, 6));
    y = (x + 1 + int'($urandom_range(0, 5))) % 7;
    return (one << x) | (one << y);
  endfunction

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Called at a falling edge with requests already driven; handles one grant
  // through execution and a response held for 'hold' extra cycles.
  task automatic run_op(input int hold);
    int g;
    logic [6:0] s;
    logic [31:0] a, b, ed;
    logic [3:0] ef;
    logic setf, ee, eu;
    if (p_valid[0] && p_valid[1]) g = int'(prio_m);
    else if (p_valid[0]) g = 0;
    else if (p_valid[1]) g = 1;
    else g = -1;
    #1;
    chk("idle_ready0", {31'd0, req0_ready}, {31'd0, g == 0});
    chk("idle_ready1", {31'd0, req1_ready}, {31'd0, g == 1});
    if (g < 0) begin
      @(negedge clk);
      return;
    end
    s = p_sel[g]; a = p_a[g]; b = p_b[g]; setf = p_setf[g];
    ref_op(s, a, b, setf, ed, ef, ee, eu);
    @(posedge clk);
    @(negedge clk);
    p_valid[g] = 1'b0;
    #1;
    chk("exec_alu_sel", {25'd0, alu_sel}, {25'd0, ee ? 7'd0 : s});
    chk("exec_alu_a", alu_a, a);
    chk("exec_alu_b", alu_b, b);
    chk("exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("exec_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    if (eu) flags_m = ef;
    prio_m = (g == 0);
    @(negedge clk);
    for (int k = 0; k <= hold; k++) begin
      chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("rsp_id", {31'd0, rsp_id}, g);
      chk("rsp_data", rsp_data, ed);
      chk("rsp_flags", {28'd0, rsp_flags}, {28'd0, ef});
      chk("rsp_err", {31'd0, rsp_err}, {31'd0, ee});
      chk("flags_q", {28'd0, flags_q}, {28'd0, flags_m});
      chk("resp_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      if (k < hold) @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("done_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("done_alu_sel", {25'd0, alu_sel}, 32'd0);
    $display("op %0d: id=%0d sel=%b a=%h b=%h setf=%0d -> data=%h flags=%b err=%0d flags_q=%b",
             op_no, g, s, a, b, setf, ed, ef, ee, flags_m);
    op_no++;
  endtask

  initial begin
    for (int p = 0; p < 2; p++) begin
      p_valid[p] = 1'b0; p_sel[p] = '0; p_a[p] = '0; p_b[p] = '0; p_setf[p] = 1'b0;
    end
    rsp_ready = 1'b0;
    flags_m = 4'd0;
    prio_m = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_alu_sel", {25'd0, alu_sel}, 32'd0);
    chk("reset_flags_q", {28'd0, flags_q}, 32'd0);
    chk("reset_rsp_data", rsp_data, 32'd0);
    chk("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("reset_alu_a", alu_a, 32'd0);
    reset_n = 1'b1;

    // Stray rsp_ready while idle must be ignored.
    rsp_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("idle_stray_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    end
    rsp_ready = 1'b0;

    set_req(0, OP_ADD, 32'd5, 32'd7, 1'b1);  run_op(0);
    set_req(1, OP_SUB, 32'd3, 32'd3, 1'b0);  run_op(0);
    set_req(1, OP_CMP, 32'd3, 32'd3, 1'b0);  run_op(0);

    // Both requesters contending: grants alternate.
    for (int i = 0; i < 4; i++) begin
      for (int p = 0; p < 2; p++)
        if (!p_valid[p]) set_req(p, OP_ADD, $urandom, $urandom, 1'(p));
      run_op(0);
    end

    // Long backpressure with the other requester waiting.
    for (int p = 0; p < 2; p++)
      if (!p_valid[p]) set_req(p, OP_EOR, 32'hA5A5_0F0F, 32'h0F0F_A5A5, 1'b1);
    run_op(5);
    p_valid[0] = 1'b0; p_valid[1] = 1'b0;

    set_req(0, 7'b0000011, 32'd9, 32'd4, 1'b1);            run_op(0);
    set_req(1, OP_ADD, 32'h7FFF_FFFF, 32'd1, 1'b1);        run_op(0);
    set_req(0, OP_AND, 32'hFFFF_0001, 32'h8000_FFFF, 1'b1); run_op(0);

    for (int i = 0; i < 40; i++) begin
      for (int p = 0; p < 2; p++)
        if (!p_valid[p] && ($urandom_range(0, 1) == 1))
          set_req(p, rand_sel(), rand_val(), rand_val(), 1'($urandom_range(0, 1)));
      if (!p_valid[0] && !p_valid[1])
        set_req(int'($urandom_range(0, 1)), rand_sel(), rand_val(), rand_val(), 1'($urandom_range(0, 1)));
      run_op(int'($urandom_range(0, 2)));
    end
    p_valid[0] = 1'b0; p_valid[1] = 1'b0;

    // Reset asserted while an op is executing: the op vanishes.
    set_req(0, OP_ADD, 32'd1, 32'd2, 1'b1);
    #1;
    chk("prereset_ready0", {31'd0, req0_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    p_valid[0] = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("midreset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midreset_alu_sel", {25'd0, alu_sel}, 32'd0);
    chk("midreset_alu_a", alu_a, 32'd0);
    chk("midreset_flags_q", {28'd0, flags_q}, 32'd0);
    chk("midreset_rsp_data", rsp_data, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    flags_m = 4'd0;
    prio_m = 1'b0;
    rsp_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("postreset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    end
    rsp_ready = 1'b0;
    set_req(1, OP_ORR, 32'h0000_00F0, 32'h0000_000F, 1'b1); run_op(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
